// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host-request to SPI-frame controller for a serial RAM slave.
//   A write sends {00,addr} then {01,wdata}; a read sends {10,addr} then {11,8'h00},
//   keeps SS_n low through a turnaround, and shifts 8 MISO bits MSB first.
//   Each frame is a command-select bit (cmd[1]) followed by 10 frame bits MSB first.
// Parameters:
//   GAP_CYCLES     SS_n-high cycles between the address and data frames (1..15)
//   RD_TURNAROUND  cycles between the last read-data frame bit and the first MISO sample (0..7)
// Optional feature (macro SPI_MASTER_CTRL_ADDR_CACHE_EN):
//   caches the last-sent write and read addresses; a repeated address skips its address frame.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_wr, req_addr, req_wdata        request fields, captured at acceptance
//   rsp_valid, rsp_rdata               one-cycle completion pulse and read data (0 for writes)
//   SS_n, MOSI, MISO                   SPI slave select, serial out, serial in
module spi_master_ctrl #(
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned RD_TURNAROUND = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned FRAME_LAST = 10;
    localparam int unsigned RX_LAST    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP,
        ST_TURN,
        ST_RX,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               data_ph_q, data_ph_d;
    logic               wr_q, wr_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic [7:0]         payload;
    logic [10:0]        frame_seq;

`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
    logic [7:0]         wa_q, wa_d;
    logic               wa_vld_q, wa_vld_d;
    logic [7:0]         ra_q, ra_d;
    logic               ra_vld_q, ra_vld_d;
`endif

    // State and output registers; outputs are registered from next-state values
    // so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_ph_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
            wa_q      <= '0;
            wa_vld_q  <= 1'b0;
            ra_q      <= '0;
            ra_vld_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_ph_q <= data_ph_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
            wa_q      <= wa_d;
            wa_vld_q  <= wa_vld_d;
            ra_q      <= ra_d;
            ra_vld_q  <= ra_vld_d;
`endif
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_ph_d = data_ph_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
        wa_d      = wa_q;
        wa_vld_d  = wa_vld_q;
        ra_d      = ra_q;
        ra_vld_d  = ra_vld_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d   = ST_FRAME;
                    cnt_d     = '0;
                    wr_d      = req_wr;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    data_ph_d = 1'b0;
`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
                    // A hit on the same-type cached address starts at the data frame.
                    if (req_wr) begin
                        if (wa_vld_q && (wa_q == req_addr)) begin
                            data_ph_d = 1'b1;
                        end else begin
                            wa_d     = req_addr;
                            wa_vld_d = 1'b1;
                        end
                    end else begin
                        if (ra_vld_q && (ra_q == req_addr)) begin
                            data_ph_d = 1'b1;
                        end else begin
                            ra_d     = req_addr;
                            ra_vld_d = 1'b1;
                        end
                    end
`endif
                end
            end
            ST_FRAME: begin
                if (cnt_q == CNT_W'(FRAME_LAST)) begin
                    cnt_d = '0;
                    if (!data_ph_q) begin
                        state_d = ST_GAP;
                    end else if (wr_q) begin
                        state_d = ST_DONE;
                        rdata_d = '0;
                    end else if (RD_TURNAROUND == 0) begin
                        state_d = ST_RX;
                    end else begin
                        state_d = ST_TURN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d   = ST_FRAME;
                    cnt_d     = '0;
                    data_ph_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (cnt_q == CNT_W'(RD_TURNAROUND - 1)) begin
                    state_d = ST_RX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RX: begin
                shift_d = {shift_q[6:0], MISO};
                if (cnt_q == CNT_W'(RX_LAST)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    rdata_d = shift_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Serial sequence: select bit (cmd[1]) then {cmd, payload} MSB first.
        payload   = data_ph_d ? (wr_d ? wdata_d : 8'h00) : addr_d;
        frame_seq = {~wr_d, ~wr_d, data_ph_d, payload};

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        ss_n_d  = !(state_d inside {ST_FRAME, ST_TURN, ST_RX});
        mosi_d  = (state_d == ST_FRAME) ? frame_seq[CNT_W'(FRAME_LAST) - cnt_d] : 1'b0;
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: behavioural SPI RAM slave plus a transaction-level
// reference model (frame list, read data, completion latency, address cache).
module tb_spi_master_ctrl;

    localparam int GAP = 1;
    localparam int RD  = 2;
`ifdef SPI_MASTER_CTRL_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .GAP_CYCLES    (GAP),
        .RD_TURNAROUND (RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .MISO      (miso)
    );

    // ---------------- SPI RAM slave ----------------
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [10:0] frames [$];
    int          st_start [$];
    int          st_len [$];
    int          cyc = 0;
    int          k = 0;
    int          cur_start = 0;
    int          mosi_err = 0;
    logic [9:0]  sh = '0;
    logic [10:0] fr;
    logic [7:0]  s_wa = '0;
    logic [7:0]  s_ra = '0;
    logic [7:0]  rx_byte = '0;
    bit          rd_active = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ss_n === 1'b0) begin
            if (k == 0) cur_start = cyc;
            if (k <= 10) begin
                if (k == 10) begin
                    fr = {sh, mosi};
                    frames.push_back(fr);
                    case (fr[9:8])
                        2'b00: s_wa = fr[7:0];
                        2'b01: mem[s_wa] = fr[7:0];
                        2'b10: s_ra = fr[7:0];
                        default: begin
                            rx_byte   = mem[s_ra];
                            rd_active = 1'b1;
                        end
                    endcase
                end
                sh = {sh[8:0], mosi};
            end else if (mosi !== 1'b0) begin
                mosi_err++;
            end
            if (rd_active && k >= 11 + RD && k <= 18 + RD)
                miso = rx_byte[3'(18 + RD - k)];
            else
                miso = 1'($urandom);
            k++;
        end else begin
            if (k > 0) begin
                st_start.push_back(cur_start);
                st_len.push_back(k);
            end
            if (mosi !== 1'b0) mosi_err++;
            k = 0;
            rd_active = 1'b0;
            miso = 1'($urandom);
        end
    end

    // ---------------- reference model ----------------
    logic [10:0] exp_frames [$];
    logic [7:0]  exp_rdata;
    int          exp_lat;
    logic [7:0]  m_wa = '0;
    logic [7:0]  m_ra = '0;
    bit          m_wa_v = 1'b0;
    bit          m_ra_v = 1'b0;

    task automatic model_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        bit skip;
        skip = 1'b0;
        exp_frames.delete();
        if (CACHE) begin
            if (wr) begin
                skip = m_wa_v && (m_wa == addr);
                m_wa = addr;
                m_wa_v = 1'b1;
            end else begin
                skip = m_ra_v && (m_ra == addr);
                m_ra = addr;
                m_ra_v = 1'b1;
            end
        end
        if (!skip) exp_frames.push_back({~wr, ~wr, 1'b0, addr});
        exp_frames.push_back({~wr, ~wr, 1'b1, (wr ? wdata : 8'h00)});
        if (wr) begin
            ref_mem[addr] = wdata;
            exp_rdata = 8'h00;
        end else begin
            exp_rdata = ref_mem[addr];
        end
        exp_lat = (skip ? 0 : 11 + GAP) + 11 + (wr ? 0 : RD + 8);
    endtask

    // Drive one request from a negedge; returns at the negedge showing rsp_valid.
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output int lat);
        int n;
        frames.delete();
        st_start.delete();
        st_len.delete();
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (n >= 100 || lat >= 200) lat = -1;
        rdata = rsp_rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (ss_n !== 1'b1) begin tests_failed++; $display("FAIL reset_ss_n: got %b expected 1", ss_n); end
        tests_run++;
        if (mosi !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        tests_run++;
        if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        tests_run++;
        if (rsp_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_at_release: got %b expected 0", req_ready); end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_first_cycle: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_basic();
        logic [7:0] rd;
        int lat;
        model_txn(1'b1, 8'h03, 8'hF0);
        run_txn(1'b1, 8'h03, 8'hF0, rd, lat);
        tests_run++;
        if (frames.size() != 2 || frames[0] !== 11'b0_00_0000_0011 || frames[1] !== 11'b0_01_1111_0000) begin
            tests_failed++;
            $display("FAIL wr_frames: got %0d frames, expected 2 frames 003/0f0", frames.size());
        end
        tests_run++;
        if (rd !== 8'h00) begin tests_failed++; $display("FAIL wr_rdata: got %h expected 00", rd); end
        tests_run++;
        if (lat !== 22 + GAP) begin tests_failed++; $display("FAIL wr_latency: got %0d expected %0d", lat, 22 + GAP); end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_pulse_width: got %b expected 0", rsp_valid); end
        tests_run++;
        if (st_len.size() != 2 || st_len[0] != 11 || st_len[1] != 11 || st_start[1] - (st_start[0] + 11) != GAP) begin
            tests_failed++;
            $display("FAIL wr_ss_timing: got %0d stretches, expected 2 of 11 cycles with %0d gap", st_len.size(), GAP);
        end
        tests_run++;
        if (mem[8'h03] !== 8'hF0) begin tests_failed++; $display("FAIL wr_ram: got %h expected f0", mem[8'h03]); end
    endtask

    task automatic test_read_basic();
        logic [7:0] rd;
        int lat;
        model_txn(1'b0, 8'h0F, 8'h00);
        run_txn(1'b0, 8'h0F, 8'h00, rd, lat);
        tests_run++;
        if (frames.size() != 2 || frames[0] !== 11'b1_10_0000_1111 || frames[1] !== 11'b1_11_0000_0000) begin
            tests_failed++;
            $display("FAIL rd_frames: got %0d frames, expected 2 frames 60f/700", frames.size());
        end
        tests_run++;
        if (rd !== 8'hA5) begin tests_failed++; $display("FAIL rd_rdata: got %h expected a5", rd); end
        tests_run++;
        if (lat !== 22 + GAP + RD + 8) begin tests_failed++; $display("FAIL rd_latency: got %0d expected %0d", lat, 22 + GAP + RD + 8); end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rd_hold: got valid %b data %h expected 0/a5", rsp_valid, rsp_rdata);
        end
        tests_run++;
        if (st_len.size() != 2 || st_len[1] != 11 + RD + 8) begin
            tests_failed++;
            $display("FAIL rd_ss_low: got %0d stretches, expected second of %0d cycles", st_len.size(), 11 + RD + 8);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, wd, ad;
        bit wr, bad;
        int lat;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom);
            ad = 8'h40 + 8'($urandom_range(0, 5));
            wd = 8'($urandom);
            model_txn(wr, ad, wd);
            run_txn(wr, ad, wd, rd, lat);
            bad = (frames.size() != exp_frames.size());
            if (!bad) foreach (exp_frames[i]) if (frames[i] !== exp_frames[i]) bad = 1'b1;
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL rnd_frames[%0d]: got %0d frames, expected %0d (wr=%b addr=%h)", t, frames.size(), exp_frames.size(), wr, ad);
            end
            tests_run++;
            if (rd !== exp_rdata) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", t, rd, exp_rdata); end
            tests_run++;
            if (lat !== exp_lat) begin tests_failed++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, exp_lat); end
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rdata) begin
                tests_failed++;
                $display("FAIL rnd_hold[%0d]: got valid %b data %h expected 0/%h", t, rsp_valid, rsp_rdata, exp_rdata);
            end
        end
        tests_run++;
        if (mosi_err !== 0) begin tests_failed++; $display("FAIL mosi_idle_zero: got %0d violations expected 0", mosi_err); end
    endtask

    task automatic test_back_to_back();
        int n, lat, lat_w, ready_bad, nw, last_end, gap;
        frames.delete();
        st_start.delete();
        st_len.delete();
        model_txn(1'b1, 8'h10, 8'h55);
        lat_w = exp_lat;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 8'h55;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_wr    = 1'b0;
        req_wdata = 8'($urandom);
        lat = 0;
        ready_bad = 0;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            if (req_ready !== 1'b0) ready_bad++;
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (lat !== lat_w) begin tests_failed++; $display("FAIL b2b_wr_latency: got %0d expected %0d", lat, lat_w); end
        tests_run++;
        if (ready_bad !== 0) begin tests_failed++; $display("FAIL b2b_ready_busy: got %0d high cycles expected 0", ready_bad); end
        model_txn(1'b0, 8'h10, 8'h00);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_idle: got %b expected 1", req_ready); end
        nw = st_start.size();
        last_end = (nw > 0) ? st_start[nw-1] + st_len[nw-1] : 0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        tests_run++;
        if (rsp_rdata !== exp_rdata) begin tests_failed++; $display("FAIL b2b_rdata: got %h expected %h", rsp_rdata, exp_rdata); end
        tests_run++;
        if (lat !== exp_lat) begin tests_failed++; $display("FAIL b2b_rd_latency: got %0d expected %0d", lat, exp_lat); end
        @(negedge clk);
        gap = (st_start.size() > nw && nw > 0) ? st_start[nw] - last_end : -1;
        tests_run++;
        if (gap < 2) begin tests_failed++; $display("FAIL b2b_ss_gap: got %0d expected >= 2", gap); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, rd;
        int n, lat, vcount;
        d = 8'($urandom);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'hC3;
        req_wdata = d ^ 8'hFF;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (11 + GAP + 5) @(negedge clk);
        tests_run++;
        if (ss_n !== 1'b0) begin tests_failed++; $display("FAIL mid_in_frame: got ss_n %b expected 0", ss_n); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ss_n !== 1'b1) begin tests_failed++; $display("FAIL mid_ss_n_async: got %b expected 1", ss_n); end
        tests_run++;
        if (mosi !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_outs: got mosi %b ready %b rdata %h expected 0/0/00", mosi, req_ready, rsp_rdata);
        end
        m_wa_v = 1'b0;
        m_ra_v = 1'b0;
        vcount = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid === 1'b1) vcount++; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (rsp_valid === 1'b1) vcount++; end
        tests_run++;
        if (vcount !== 0) begin tests_failed++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", vcount); end
        tests_run++;
        if (mem[8'hC3] !== ref_mem[8'hC3]) begin tests_failed++; $display("FAIL mid_ram_untouched: got %h expected %h", mem[8'hC3], ref_mem[8'hC3]); end
        model_txn(1'b1, 8'hC3, d);
        run_txn(1'b1, 8'hC3, d, rd, lat);
        tests_run++;
        if (lat !== exp_lat || frames.size() != 2) begin
            tests_failed++;
            $display("FAIL mid_next_write: got latency %0d frames %0d expected %0d/2", lat, frames.size(), exp_lat);
        end
        tests_run++;
        if (mem[8'hC3] !== d) begin tests_failed++; $display("FAIL mid_next_ram: got %h expected %h", mem[8'hC3], d); end
        @(negedge clk);
    endtask

    task automatic test_cache();
        logic [7:0] rd;
        int lat, exp_n;
        bit bad;
        for (int r = 0; r < 2; r++) begin
            model_txn(1'b0, 8'h20, 8'h00);
            run_txn(1'b0, 8'h20, 8'h00, rd, lat);
            exp_n = (r == 1 && CACHE) ? 1 : 2;
            bad = (frames.size() != exp_n) || (frames.size() != exp_frames.size());
            if (!bad) foreach (exp_frames[i]) if (frames[i] !== exp_frames[i]) bad = 1'b1;
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL cache_frames[%0d]: got %0d frames expected %0d", r, frames.size(), exp_n);
            end
            tests_run++;
            if (rd !== exp_rdata || lat !== exp_lat) begin
                tests_failed++;
                $display("FAIL cache_read[%0d]: got data %h latency %0d expected %h/%0d", r, rd, lat, exp_rdata, exp_lat);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h0F]     = 8'hA5;
        ref_mem[8'h0F] = 8'hA5;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_cache();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
